// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared encodings for the md_unit multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // Wide enough for any DATA_W up to 64; truncated at the point of use.
  localparam logic [63:0] DIV0_LO = '1;

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// mdu_step : one radix-2 iteration (shift-add multiply / restoring divide)
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_step
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  i_mode,
  input  logic [2*DATA_W-1:0]   i_acc,
  input  logic [DATA_W-1:0]     i_operand,
  output logic [2*DATA_W-1:0]   o_acc_next
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_rem_sh;
  logic [DATA_W:0] w_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
  always_comb begin
    w_sum      = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_rem_sh   = i_acc[2*DATA_W-1:DATA_W-1];
    w_diff     = w_rem_sh - {1'b0, i_operand};
    o_acc_next = {w_sum, i_acc[DATA_W-1:1]};
    if (i_mode == MODE_DIV) begin
      if (w_diff[DATA_W]) begin
        o_acc_next = {w_rem_sh[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b0};
      end else begin
        o_acc_next = {w_diff[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// md_unit : iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// Optional macro MDU_EARLY_OUT_EN: zero-operand multiply / divide-by-zero skip CALC.
// Rev 1.0
// ============================================================================
`default_nettype none

module md_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_BusA,
  input  logic [DATA_W-1:0] i_BusB,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int                 CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0]  C_DIV0_LO  = DATA_W'(DIV0_LO);

  state_e                r_state;
  state_e                w_next_state;
  logic                  r_is_div;
  logic                  r_neg_lo;
  logic                  r_neg_hi;
  logic                  r_div0;
  logic [2*DATA_W-1:0]   r_acc;
  logic [2*DATA_W-1:0]   w_acc_next;
  logic [DATA_W-1:0]     r_opnd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;

  logic                  w_div;
  logic                  w_sa;
  logic                  w_sb;
  logic [DATA_W-1:0]     w_mag_a;
  logic [DATA_W-1:0]     w_mag_b;
  logic                  w_a_zero;
  logic                  w_b_zero;
  logic                  w_early;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_quo;
  logic [DATA_W-1:0]     w_rem;

  assign w_div    = i_op[1];
  assign w_sa     = ~i_op[0] & i_BusA[DATA_W-1];
  assign w_sb     = ~i_op[0] & i_BusB[DATA_W-1];
  assign w_mag_a  = w_sa ? -i_BusA : i_BusA;
  assign w_mag_b  = w_sb ? -i_BusB : i_BusB;
  assign w_a_zero = (i_BusA == '0);
  assign w_b_zero = (i_BusB == '0);

`ifdef MDU_EARLY_OUT_EN
  assign w_early = w_div ? w_b_zero : (w_a_zero | w_b_zero);
`else
  assign w_early = 1'b0;
`endif

  mdu_step #(.DATA_W(DATA_W)) u_step (
    .i_mode     (r_is_div ? MODE_DIV : MODE_MUL),
    .i_acc      (r_acc),
    .i_operand  (r_opnd),
    .o_acc_next (w_acc_next)
  );

  // Divide-by-zero leaves |A| as the remainder magnitude, so negating by sign(A)
  // restores the original A in HI; only the quotient needs overriding.
  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quo  = r_div0 ? C_DIV0_LO
                         : (r_neg_lo ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0]);
  assign w_rem  = r_neg_hi ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next_state = w_early ? ST_FIX : ST_CALC;
      ST_CALC: if (r_cnt == C_CNT_LAST) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_div0   <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= (r_state == ST_FIX);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_is_div <= w_div;
            r_cnt    <= '0;
            r_div0   <= w_div & w_b_zero;
            if (w_div) begin
              r_neg_lo <= w_sa ^ w_sb;
              r_neg_hi <= w_sa;
              r_opnd   <= w_mag_b;
              r_acc    <= w_early ? {w_mag_a, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, w_mag_a};
            end else begin
              r_neg_lo <= w_sa ^ w_sb;
              r_neg_hi <= w_sa ^ w_sb;
              r_opnd   <= w_mag_a;
              r_acc    <= w_early ? '0 : {{DATA_W{1'b0}}, w_mag_b};
            end
          end else begin
            if (i_mthi) r_hi <= i_wdata;
            if (i_mtlo) r_lo <= i_wdata;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          r_hi <= r_is_div ? w_rem : w_prod[2*DATA_W-1:DATA_W];
          r_lo <= r_is_div ? w_quo : w_prod[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// tb_md_unit : scoreboard bench for md_unit against an arithmetic reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] bus_a, bus_b, wdata;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  md_unit #(.DATA_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_BusA(bus_a), .i_BusB(bus_b), .i_mthi(mthi), .i_mtlo(mtlo),
    .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain 64-bit arithmetic with C-style truncating signed division.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] r, output int lat);
    longint sa, sb, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: r = 64'(sa * sb);
      2'd1: r = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 0) begin
          r = {a, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end else begin
          r = {a % b, a / b};
        end
      end
    endcase
    lat = 33;
`ifdef MDU_EARLY_OUT_EN
    if ((o < 2'd2 && (a == 0 || b == 0)) || (o >= 2'd2 && b == 0)) lat = 1;
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // act: 0 plain, 1 inject start+mthi mid-op, 2 reset mid-op, 3 mthi alongside start
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int act);
    logic [63:0] r;
    int          lat;
    exp_t        e;
    wait_idle();
    model(o, a, b, r, lat);
    start = 1'b1; op = o; bus_a = a; bus_b = b;
    if (act == 3) begin
      mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
    end
    e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("hold_during_op", {hi, lo}, {m_hi, m_lo});
    if (act == 1) begin
      repeat (3) @(negedge clk);
      start = 1'b1; op = 2'd0; bus_a = $urandom; bus_b = $urandom;
      mthi = 1'b1; wdata = 32'h0000_AAAA;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      chk("ignore_while_busy", {31'd0, busy, hi}, {31'd0, 1'b1, m_hi});
    end
    if (act == 2) begin
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {busy, done, 30'd0, hi ^ lo}, 64'd0);
      chk("async_reset_hi", {32'd0, hi}, 64'd0);
      void'(exp_q.pop_back());
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_done_after_reset", {hi, lo}, 64'd0);
    end else begin
      m_hi = r[63:32]; m_lo = r[31:0];
    end
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    wait_idle();
    mthi = h; mtlo = l; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
    chk("mt_write", {hi, lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: each done pulse retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {hi, lo}, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("result_hi_lo", {hi, lo}, {e.hi, e.lo});
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_low_at_done", {63'd0, busy}, 64'd0);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = '0; bus_a = '0; bus_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, 30'd0, hi | lo}, 64'd0);
    rst_n = 1'b1;

    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'd3, 32'h0000_1234, 32'd0, 0);
    do_op(2'd2, 32'hFFFF_1234, 32'd0, 0);
    do_op(2'd3, 32'd100, 32'd7, 1);
    mt_write(1'b0, 1'b1, 32'h55);
    mt_write(1'b1, 1'b1, 32'h1357_9BDF);
    do_op(2'd0, 32'd0, 32'h1234_5678, 3);
    do_op(2'd0, 32'h0000_0123, 32'hFFFF_0000, 2);
    do_op(2'd0, 32'h0000_0123, 32'hFFFF_0000, 0);

    for (int i = 0; i < 30; i++) begin
      do_op(2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 0);
      if ($urandom_range(0, 4) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
